// File: rtl/arb_pkg.sv
// arb_pkg: shared arbitration mode encoding and the one-hot to index helper.
package arb_pkg;

  typedef enum logic {
    ARB_MODE_FIXED = 1'b0,
    ARB_MODE_RR    = 1'b1
  } arb_mode_e;

  // Vectors wider than 32 requesters are not supported by this helper.
  function automatic int onehot2idx(input logic [31:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: combinational masked priority pick, searching upward from start with wrap-around.
module arb_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] start,
  output logic [N-1:0]  winner,
  output logic          found
);

  int j;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(start) + k) % N;
      if (!found && eligible[j]) begin
        winner[j] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/param_arbiter.sv
// param_arbiter: N-way arbiter, fixed-priority or round-robin, with bounded grant hold.
// Optional starvation override when ARB_STARVE_EN is defined.
module param_arbiter
  import arb_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int MAX_HOLD     = 4,
  parameter  int STARVE_LIMIT = 8,
  localparam int IDX_W        = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               mode,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [NUM_REQ-1:0] starved
);

  localparam int              HC_W      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

  if (NUM_REQ < 2 || NUM_REQ > 32 || MAX_HOLD < 1 || STARVE_LIMIT < 2) begin : g_param_check
    $error("param_arbiter: illegal parameter value");
  end

  logic [HC_W-1:0]    hold_cnt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] force_vec;
  logic [NUM_REQ-1:0] eligible;
  logic [IDX_W-1:0]   start;
  logic [NUM_REQ-1:0] winner;
  logic               found;
  logic [IDX_W-1:0]   widx;
  logic               holder_req;
  logic               others_req;
  logic               keep;

  always_comb begin
    holder_req = |(req & grant);
    others_req = |(req & ~grant);
    keep       = holder_req && (hold_cnt < HOLD_LAST) && !(|force_vec);
    eligible   = req;
    start      = (mode == ARB_MODE_RR) ? rr_ptr : '0;
    // An expired holder steps aside only if somebody else is waiting.
    if (holder_req && !(hold_cnt < HOLD_LAST) && others_req) begin
      eligible = req & ~grant;
    end
    if (|force_vec) begin
      eligible = force_vec;
      start    = '0;
    end
  end

  arb_rr_pick #(
    .N  (NUM_REQ),
    .PW (IDX_W)
  ) u_pick (
    .eligible (eligible),
    .start    (start),
    .winner   (winner),
    .found    (found)
  );

  assign widx = IDX_W'(onehot2idx(32'(winner)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      hold_cnt    <= '0;
      rr_ptr      <= '0;
    end else if (keep) begin
      hold_cnt <= hold_cnt + HC_W'(1);
    end else if (found) begin
      grant       <= winner;
      grant_valid <= 1'b1;
      grant_idx   <= widx;
      hold_cnt    <= '0;
      rr_ptr      <= (widx == IDX_W'(NUM_REQ - 1)) ? '0 : widx + IDX_W'(1);
    end else begin
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
    end
  end

`ifdef ARB_STARVE_EN
  localparam int              WC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [WC_W-1:0] LIMIT = WC_W'(STARVE_LIMIT);

  logic [WC_W-1:0]    wait_cnt [NUM_REQ];
  logic [WC_W-1:0]    wait_nxt [NUM_REQ];
  logic [NUM_REQ-1:0] starved_q;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      wait_nxt[i] = wait_cnt[i];
      if (!req[i] || grant[i]) begin
        wait_nxt[i] = '0;
      end else if (wait_cnt[i] != LIMIT) begin
        wait_nxt[i] = wait_cnt[i] + WC_W'(1);
      end
    end
  end

  // The flag rises in the same cycle the counter reaches the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
      starved_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        wait_cnt[i]  <= wait_nxt[i];
        starved_q[i] <= (wait_nxt[i] == LIMIT);
      end
    end
  end

  assign starved   = starved_q;
  assign force_vec = starved_q & req;
`else
  assign starved   = '0;
  assign force_vec = '0;
`endif

endmodule

// File: tb/tb_param_arbiter.sv
// tb_param_arbiter: directed checks of param_arbiter in fixed, round-robin and hold scenarios.
`timescale 1ns/1ps
module tb_param_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       mode;

  logic [3:0] a_grant, b_grant, c_grant;
  logic       a_valid, b_valid, c_valid;
  logic [1:0] a_idx, b_idx, c_idx;
  logic [3:0] a_starved, b_starved, c_starved;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_arbiter #(.NUM_REQ(4), .MAX_HOLD(4), .STARVE_LIMIT(8)) dut_a (
    .clk(clk), .rst(rst), .req(req), .mode(mode),
    .grant(a_grant), .grant_valid(a_valid), .grant_idx(a_idx), .starved(a_starved)
  );

  param_arbiter #(.NUM_REQ(4), .MAX_HOLD(1), .STARVE_LIMIT(8)) dut_b (
    .clk(clk), .rst(rst), .req(req), .mode(mode),
    .grant(b_grant), .grant_valid(b_valid), .grant_idx(b_idx), .starved(b_starved)
  );

  param_arbiter #(.NUM_REQ(4), .MAX_HOLD(8), .STARVE_LIMIT(2)) dut_c (
    .clk(clk), .rst(rst), .req(req), .mode(mode),
    .grant(c_grant), .grant_valid(c_valid), .grant_idx(c_idx), .starved(c_starved)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_g;
    logic [3:0] rr_seq [5];
    rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
    rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001;

    // Reset with all requests active.
    rst = 1'b1; req = 4'b1111; mode = 1'b0;
    tick(); tick();
    check("rst_grant", a_grant, 4'b0000);
    check("rst_valid", a_valid, 1'b0);
    check("rst_idx", a_idx, 2'd0);
    check("rst_starved", a_starved, 4'b0000);
    rst = 1'b0;
    tick();
    check("first_grant", a_grant, 4'b0001);
    check("first_valid", a_valid, 1'b1);
    check("first_idx", a_idx, 2'd0);

    // Fixed mode alternation under MAX_HOLD=4.
    req = 4'b1010; mode = 1'b0;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_g = (((k - 1) / 4) % 2 == 1) ? 4'b1000 : 4'b0010;
      check($sformatf("fix_hold_%0d", k), a_grant, exp_g);
      check($sformatf("fix_idx_%0d", k), a_idx, (exp_g == 4'b1000) ? 2'd3 : 2'd1);
      check($sformatf("onehot_%0d", k), $onehot0(a_grant), 1'b1);
    end

    // Round robin with MAX_HOLD=1.
    req = 4'b1111; mode = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("rr_seq_%0d", k), b_grant, rr_seq[k]);
    end

    // Holder drops its request mid-hold, then all requests drop.
    req = 4'b0011; mode = 1'b0;
    do_reset();
    tick();
    check("rel_first", a_grant, 4'b0001);
    req = 4'b0010;
    tick();
    check("rel_move", a_grant, 4'b0010);
    check("rel_move_idx", a_idx, 2'd1);
    req = 4'b0000;
    tick();
    check("idle_grant", a_grant, 4'b0000);
    check("idle_valid", a_valid, 1'b0);
    check("idle_idx", a_idx, 2'd0);

    // Asynchronous reset in the middle of a hold.
    req = 4'b0100; mode = 1'b0;
    do_reset();
    tick(); tick();
    check("mid_hold_grant", a_grant, 4'b0100);
    check("mid_hold_idx", a_idx, 2'd2);
    #2 rst = 1'b1;
    #1;
    check("async_grant", a_grant, 4'b0000);
    check("async_valid", a_valid, 1'b0);
    check("async_idx", a_idx, 2'd0);
    mode = 1'b1; req = 4'b1111;
    tick();
    rst = 1'b0;
    tick();
    check("rr_ptr_restart", a_grant, 4'b0001);

`ifdef ARB_STARVE_EN
    // Starvation override breaking a long hold.
    req = 4'b0011; mode = 1'b0;
    do_reset();
    tick();
    check("stv_g1", c_grant, 4'b0001);
    check("stv_s1", c_starved, 4'b0000);
    tick();
    check("stv_g2", c_grant, 4'b0001);
    check("stv_s2", c_starved, 4'b0010);
    tick();
    check("stv_g3", c_grant, 4'b0010);
    check("stv_s3", c_starved, 4'b0010);
    tick();
    check("stv_g4", c_grant, 4'b0010);
    check("stv_s4", c_starved, 4'b0000);
`else
    check("nostarve_c", c_starved, 4'b0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
